// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, radix-2 Booth multiply
// and restoring divide, sequenced by a start/done handshake with held results.
module seq_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4:0]              op,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    carry_out,
  output logic                    div_by_zero,
  output logic                    op_err
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [4:0] OP_OR   = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_ADDU = 5'd4;
  localparam logic [4:0] OP_MUL  = 5'd5;
  localparam logic [4:0] OP_DIV  = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_NEG  = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd10;
  localparam logic [4:0] OP_SHR  = 5'd11;
  localparam logic [4:0] OP_SHRA = 5'd12;
  localparam logic [4:0] OP_ROL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t         state;
  logic [W:0]     acc;      // Booth accumulator / division partial remainder
  logic [W-1:0]   q_reg;    // multiplier / dividend, shifts into quotient
  logic [W-1:0]   m_reg;    // multiplicand / divisor magnitude
  logic           q_m1;
  logic           sign_q;
  logic           sign_r;
  logic [CW-1:0]  cnt;

  function automatic logic [2*W-1:0] zext(input logic [W-1:0] v);
    return {{W{1'b0}}, v};
  endfunction

  function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  // Single-cycle datapath
  logic [SHAMT_WIDTH-1:0] sh;
  logic [W:0]             add_sum;
  logic [W:0]             sub_diff;
  logic [W-1:0]           rol_v;
  logic [W-1:0]           ror_v;
  logic [W-1:0]           shra_v;
  logic [2*W-1:0]         fast_res;
  logic                   fast_carry;
  logic                   fast_dbz;
  logic                   fast_err;

  assign sh       = B[SHAMT_WIDTH-1:0];
  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_diff = {1'b0, A} - {1'b0, B};
  assign shra_v   = $signed(A) >>> sh;
  // A shift by the full width yields zero, so amount 0 leaves A unchanged.
  assign rol_v    = (A << sh) | (A >> (W - int'(sh)));
  assign ror_v    = (A >> sh) | (A << (W - int'(sh)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_dbz   = 1'b0;
    fast_err   = 1'b0;
    case (op)
      OP_OR:   fast_res = zext(A | B);
      OP_AND:  fast_res = zext(A & B);
      OP_ADD:  begin fast_res = sext(add_sum[W-1:0]);  fast_carry = add_sum[W];  end
      OP_SUB:  begin fast_res = sext(sub_diff[W-1:0]); fast_carry = sub_diff[W]; end
      OP_ADDU: begin fast_res = {{(W-1){1'b0}}, add_sum}; fast_carry = add_sum[W]; end
      OP_MUL:  ;
      OP_DIV:  begin fast_res = {A, {W{1'b1}}}; fast_dbz = 1'b1; end
      OP_XOR:  fast_res = zext(A ^ B);
      OP_NOT:  fast_res = zext(~A);
      OP_NEG:  fast_res = sext('0 - A);
      OP_SHL:  fast_res = zext(A << sh);
      OP_SHR:  fast_res = zext(A >> sh);
      OP_SHRA: fast_res = zext(shra_v);
      OP_ROL:  fast_res = zext(rol_v);
      OP_ROR:  fast_res = zext(ror_v);
      default: fast_err = 1'b1;
    endcase
  end

  // Booth step; accumulator is one bit wider so subtracting the most negative
  // multiplicand cannot overflow.
  logic [W:0]   m_ext;
  logic [W:0]   booth_sum;
  logic [W:0]   nxt_acc_mul;
  logic [W-1:0] nxt_q_mul;

  assign m_ext = {m_reg[W-1], m_reg};

  always_comb begin
    booth_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: ;
    endcase
  end

  assign nxt_acc_mul = {booth_sum[W], booth_sum[W:1]};
  assign nxt_q_mul   = {booth_sum[0], q_reg[W-1:1]};

  // Restoring division step on magnitudes, with sign fix-up on the final step
  logic [W:0]   div_shift;
  logic [W:0]   div_trial;
  logic         div_fits;
  logic [W:0]   nxt_rem;
  logic [W-1:0] nxt_q_div;
  logic [W-1:0] quo_fix;
  logic [W-1:0] rem_fix;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;

  assign div_shift = {acc[W-1:0], q_reg[W-1]};
  assign div_trial = div_shift - {1'b0, m_reg};
  assign div_fits  = ~div_trial[W];
  assign nxt_rem   = div_fits ? div_trial : div_shift;
  assign nxt_q_div = {q_reg[W-2:0], div_fits};
  assign quo_fix   = sign_q ? ('0 - nxt_q_div) : nxt_q_div;
  assign rem_fix   = sign_r ? ('0 - nxt_rem[W-1:0]) : nxt_rem[W-1:0];
  assign a_mag     = A[W-1] ? ('0 - A) : A;
  assign b_mag     = B[W-1] ? ('0 - B) : B;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      q_m1        <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            carry_out   <= 1'b0;
            div_by_zero <= 1'b0;
            op_err      <= 1'b0;
            if (op == OP_MUL) begin
              acc   <= '0;
              m_reg <= A;
              q_reg <= B;
              q_m1  <= 1'b0;
              cnt   <= CW'(W);
              state <= MUL_RUN;
            end else if (op == OP_DIV && B != '0) begin
              acc    <= '0;
              q_reg  <= a_mag;
              m_reg  <= b_mag;
              sign_q <= A[W-1] ^ B[W-1];
              sign_r <= A[W-1];
              cnt    <= CW'(W);
              state  <= DIV_RUN;
            end else begin
              result      <= fast_res;
              carry_out   <= fast_carry;
              div_by_zero <= fast_dbz;
              op_err      <= fast_err;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        MUL_RUN: begin
          acc   <= nxt_acc_mul;
          q_reg <= nxt_q_mul;
          q_m1  <= q_reg[0];
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result <= {nxt_acc_mul[W-1:0], nxt_q_mul};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DIV_RUN: begin
          acc   <= nxt_rem;
          q_reg <= nxt_q_div;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            result <= {rem_fix, quo_fix};
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic          carry_out;
  logic          div_by_zero;
  logic          op_err;

  int vectors = 0;
  int miscompares = 0;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference model straight from the operation definitions.
  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [63:0] r, output logic c, output logic dz,
                                output logic er);
    logic [32:0] s;
    logic [31:0] t;
    logic [63:0] dbl;
    longint      qa, qb;
    logic [31:0] qv, rv;
    int          amt;
    r = '0; c = 1'b0; dz = 1'b0; er = 1'b0;
    amt = int'(b[4:0]);
    case (o)
      5'd0:  r = {32'b0, a | b};
      5'd1:  r = {32'b0, a & b};
      5'd2:  begin s = {1'b0, a} + {1'b0, b}; c = s[32]; t = s[31:0]; r = {{32{t[31]}}, t}; end
      5'd3:  begin c = (a < b); t = a - b; r = {{32{t[31]}}, t}; end
      5'd4:  begin s = {1'b0, a} + {1'b0, b}; c = s[32]; r = {31'b0, s}; end
      5'd5:  r = longint'(signed'(a)) * longint'(signed'(b));
      5'd6:  begin
        if (b == 0) begin
          r = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else begin
          qa = longint'(signed'(a));
          qb = longint'(signed'(b));
          qv = 32'(qa / qb);
          rv = 32'(qa % qb);
          r = {rv, qv};
        end
      end
      5'd7:  r = {32'b0, a ^ b};
      5'd8:  r = {32'b0, ~a};
      5'd9:  begin t = -a; r = {{32{t[31]}}, t}; end
      5'd10: r = {32'b0, a << amt};
      5'd11: r = {32'b0, a >> amt};
      5'd12: begin t = signed'(a) >>> amt; r = {32'b0, t}; end
      5'd13: begin dbl = {a, a} << amt; r = {32'b0, dbl[63:32]}; end
      5'd14: begin dbl = {a, a} >> amt; r = {32'b0, dbl[31:0]}; end
      default: er = 1'b1;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, optionally poke start
  // mid-operation, and poke start again in the DONE cycle.
  task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [63:0] e_res;
    logic        e_c, e_dz, e_err;
    int          lat, exp_lat;
    bit          busy_ok;
    model(o, a, b, e_res, e_c, e_dz, e_err);
    exp_lat = (o == 5'd5 || (o == 5'd6 && b != 0)) ? W + 1 : 1;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 5'($urandom); A = $urandom; B = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) break;
      if (poke && lat == 5) begin
        start = 1'b1; op = 5'd2; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check($sformatf("latency op%0d", o), 64'(lat), 64'(exp_lat));
    check($sformatf("busy op%0d", o), 64'(busy_ok), 64'd1);
    check($sformatf("result op%0d a=%h b=%h", o, a, b), result, e_res);
    check($sformatf("carry op%0d", o), 64'(carry_out), 64'(e_c));
    check($sformatf("dbz op%0d", o), 64'(div_by_zero), 64'(e_dz));
    check($sformatf("err op%0d", o), 64'(op_err), 64'(e_err));
    start = 1'b1; op = 5'd2; A = $urandom; B = $urandom;
    @(negedge clk);
    check("done one-shot", 64'(done), 64'd0);
    check("idle after done", 64'(busy), 64'd0);
    check("result held", result, e_res);
    start = 1'b0;
  endtask

  initial begin
    logic [4:0]  ro;
    logic [31:0] ra, rb;
    bit          saw_done;

    rst_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
    #12;
    check("rst result", result, 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst carry", 64'(carry_out), 64'd0);
    check("rst dbz", 64'(div_by_zero), 64'd0);
    check("rst err", 64'(op_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    do_op(5'd4,  32'hFFFF_FFFF, 32'd1, 1'b0);
    do_op(5'd5,  -32'sd7, 32'sd6, 1'b0);
    do_op(5'd6,  -32'sd17, 32'sd5, 1'b0);
    do_op(5'd6,  32'h1234_5678, 32'd0, 1'b0);
    do_op(5'd14, 32'h0000_0001, 32'd1, 1'b0);
    do_op(5'd12, 32'h8000_0000, 32'd4, 1'b0);
    do_op(5'd5,  32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(5'd6,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(5'd6,  32'sd17, -32'sd5, 1'b0);
    do_op(5'd13, 32'hDEAD_BEEF, 32'd32, 1'b0);
    do_op(5'd2,  32'h7FFF_FFFF, 32'd1, 1'b0);
    do_op(5'd3,  32'd3, 32'd5, 1'b0);
    do_op(5'd9,  32'h8000_0000, 32'd0, 1'b0);
    do_op(5'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(5'd5,  32'd123456, -32'sd789, 1'b1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 5'd6; A = 32'd1000; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst result", result, 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    saw_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      if ($time > 0 && rst_n === 1'b0 && busy !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("no done after reset", 64'(saw_done), 64'd0);
    do_op(5'd0, 32'h0000_00F0, 32'h0000_000F, 1'b0);

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      ro = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 14)) : 5'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'($urandom_range(0, 3));
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, multi-cycle ALU for the datapath. It is the next generation of the combinational ALU, with full shift and rotate coverage, a signed Booth multiplier and a signed restoring divider. Operations start on a start/done handshake. Results are registered and held until the next operation, so the control unit can sequence MUL/DIV without fixed wait states.

Parameters:
DATA_WIDTH, 32, operand width W; must be even and >= 4.
SHAMT_WIDTH, $clog2(DATA_WIDTH), number of B bits used as the shift/rotate amount.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  5  operation code
A  input  W  operand A
B  input  W  operand B
busy  output  1  high in MUL_RUN, DIV_RUN and DONE
done  output  1  one-cycle pulse; result valid from this cycle onward
result  output  2W  registered result, held until the next accepted start
carry_out  output  1  carry/borrow of ADD/SUB/ADDU; 0 for other ops
div_by_zero  output  1  set with done on DIV when B==0
op_err  output  1  set with done on an undefined op

Behaviour:
- Op codes:
  - 0 OR, 1 AND, 2 ADD signed, 3 SUB signed, 4 ADDU, 5 MUL signed, 6 DIV signed.
  - 7 XOR, 8 NOT A, 9 NEG A.
  - 10 SHL, 11 SHR logical, 12 SHRA, 13 ROL, 14 ROR.
  - 15–31 undefined.
- Width rules:
  - Logic, shift and rotate results are zero-extended to 2W.
  - ADD/SUB/NEG: W-bit result sign-extended to 2W.
  - ADDU: {zeros, carry, sum}, with the carry at bit W.
  - MUL: full 2W signed product.
  - DIV: result = {remainder, quotient}; quotient truncates toward zero; remainder takes the sign of A.
  - Shift/rotate amount = B[SHAMT_WIDTH-1:0]; amount 0 returns A unchanged.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - result = 0, busy = 0, done = 0, carry_out = 0, div_by_zero = 0, op_err = 0.
  - Internal counters and accumulators cleared.
  - Takes effect mid-MUL/DIV immediately; the in-flight operation is discarded and no done is produced.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
  - IDLE, start=1, op in {0–4, 7–14}: result and carry_out loaded at the same edge -> DONE. Latency 1 cycle.
  - IDLE, start=1, op=5: A and B latched, Booth accumulator cleared, counter = W -> MUL_RUN.
  - IDLE, start=1, op=6 with B!=0: operands latched as magnitudes, signs stored -> DIV_RUN.
  - IDLE, start=1, op=6 with B==0: result = {A, all ones}, div_by_zero=1 -> DONE.
  - IDLE, start=1, undefined op: result = 0, op_err=1 -> DONE.
  - MUL_RUN: one radix-2 Booth step per cycle (examine Q[0] and q-1, add/sub M, arithmetic shift right). After W steps -> DONE, with result = product.
  - DIV_RUN: one restoring step per cycle. After W steps, sign fix-up is applied, then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency from the accepting edge to done high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: W+1 cycles (W iterations, then DONE).
- Flag lifetime: carry_out, div_by_zero and op_err update only when a new op completes. Each is cleared at the start of every accepted op.
- start while busy=1 (including during DONE) is ignored and is not queued.
- A, B and op are sampled only at the accepting edge; later changes have no effect.
- Overflow cases:
  - MUL of (most negative) × (most negative) gives the correct 2W result.
  - DIV of (most negative) / -1 gives quotient = most negative and remainder 0. No error flag is raised.

Test Plan:
- W=32, op=4, A=0xFFFFFFFF, B=1 -> done 1 cycle after start; result = 64'h0000_0001_0000_0000; carry_out=1.
- op=5, A=-7, B=6 -> busy for 33 cycles; done pulses once; result = 64'hFFFF_FFFF_FFFF_FFD6.
- op=6, A=-17, B=5 -> result = {32'hFFFFFFFE, 32'hFFFFFFFD}, i.e. remainder -2 and quotient -3. Then op=6, B=0 -> div_by_zero=1, done after 1 cycle.
- op=14, A=32'h0000_0001, B=1 -> result = 64'h0000_0000_8000_0000. op=12, A=32'h8000_0000, B=4 -> result = 64'h0000_0000_F800_0000.
- Start MUL, then pulse start with op=2 at cycle 5 -> second request ignored; MUL result unaffected.
- Assert rst_n=0 at cycle 10 of DIV -> outputs are 0 asynchronously with no done. After release, op=0, A=0xF0, B=0x0F -> result = 0xFF.
